// File: rtl/sequenciador_instr.sv
`timescale 1ns/1ps
// sequenciador_instr
// Clocked instruction sequencer for the X/Y/Z register + ALU datapath.
// Takes one 3-bit opcode per valid/ready handshake. It drives the register
// control codes (tx/ty/tz) and the ALU op (tula) for a single EXEC cycle, then
// holds the registers for SETTLE_CYC cycles before pulsing done.
//
// Ports
//   clk, rst        system clock (posedge), synchronous active-high reset
//   instr_valid     opcode on instr_code is valid, held by source until accepted
//   instr_code      000 CLRLD, 001 ADD, 010 SUB, 011 DISP, 100 LOAD, others invalid
//   instr_ready     sequencer can accept (IDLE only)
//   alu_overflow    ALU overflow, sampled at the end of EXEC for ADD/SUB
//   tx, ty, tz      register control: 00 clear, 01 load, 10 hold
//   tula            ALU op: 0 = Y+X, 1 = Y-X
//   busy            high in EXEC, SETTLE, DONE
//   done, err       one-cycle completion pulse; err marks an invalid opcode
//   ovf_flag        sticky overflow, cleared by rst or CLRLD
//   instr_count     number of accepted valid opcodes, wraps
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for an opcode, registers held
// EXEC   | single cycle driving the opcode's control codes
// SETTLE | registers held while data moves, SETTLE_CYC cycles
// DONE   | done (and err) pulse, one cycle
module sequenciador_instr #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [2:0]       instr_code,
  output logic             instr_ready,
  input  logic             alu_overflow,
  output logic [1:0]       tx,
  output logic [1:0]       ty,
  output logic [1:0]       tz,
  output logic             tula,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ovf_flag,
  output logic [CNT_W-1:0] instr_count
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  localparam logic [2:0] OP_CLRLD = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_DISP  = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;

  localparam logic [1:0] T_CLR  = 2'b00;
  localparam logic [1:0] T_LD   = 2'b01;
  localparam logic [1:0] T_HOLD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SETTLE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [1:0]       tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
  logic             tula_q, tula_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    settle_d = settle_q;
    tx_d     = T_HOLD;
    ty_d     = T_HOLD;
    tz_d     = T_HOLD;
    tula_d   = tula_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ready_q gates acceptance so nothing is taken in the cycle right after reset
        if (instr_valid && ready_q) begin
          op_d = instr_code;
          if (instr_code <= OP_LOAD) begin
            state_d = S_EXEC;
            count_d = count_q + CNT_W'(1);
            case (instr_code)
              OP_CLRLD: begin
                tx_d = T_CLR;
                ty_d = T_CLR;
                tz_d = T_CLR;
              end
              OP_ADD: begin
                tx_d   = T_CLR;
                ty_d   = T_LD;
                tula_d = 1'b0;
              end
              OP_SUB: begin
                tx_d   = T_CLR;
                ty_d   = T_LD;
                tula_d = 1'b1;
              end
              OP_DISP: tz_d = T_LD;
              default: tx_d = T_LD;
            endcase
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      S_EXEC: begin
        state_d  = S_SETTLE;
        settle_d = SETTLE_LOAD;
        // ALU output is still valid for the pre-edge X/Y at this edge
        if ((op_q == OP_ADD || op_q == OP_SUB) && alu_overflow) ovf_d = 1'b1;
        if (op_q == OP_CLRLD) ovf_d = 1'b0;
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_CLRLD;
      settle_q <= '0;
      tx_q     <= T_HOLD;
      ty_q     <= T_HOLD;
      tz_q     <= T_HOLD;
      tula_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      settle_q <= settle_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      tz_q     <= tz_d;
      tula_q   <= tula_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
    end
  end

  assign tx          = tx_q;
  assign ty          = ty_q;
  assign tz          = tz_q;
  assign tula        = tula_q;
  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ovf_flag    = ovf_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_sequenciador_instr.sv
`timescale 1ns/1ps
module tb_sequenciador_instr;

  localparam logic [2:0] OP_CLRLD = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_DISP  = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [2:0] instr_code;
  logic       instr_ready;
  logic       alu_ovf;
  logic [1:0] tx, ty, tz;
  logic       tula, busy, done, err, ovf_flag;
  logic [7:0] instr_count;

  // second instance, narrow counter
  logic       v2;
  logic [2:0] c2;
  logic       ready2, busy2, done2, err2, ovf2, tula2;
  logic [1:0] tx2, ty2, tz2;
  logic [1:0] count2;

  always #5 clk = ~clk;

  sequenciador_instr #(.SETTLE_CYC(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_code(instr_code),
    .instr_ready(instr_ready), .alu_overflow(alu_ovf), .tx(tx), .ty(ty), .tz(tz),
    .tula(tula), .busy(busy), .done(done), .err(err), .ovf_flag(ovf_flag),
    .instr_count(instr_count)
  );

  sequenciador_instr #(.SETTLE_CYC(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .instr_valid(v2), .instr_code(c2),
    .instr_ready(ready2), .alu_overflow(1'b0), .tx(tx2), .ty(ty2), .tz(tz2),
    .tula(tula2), .busy(busy2), .done(done2), .err(err2), .ovf_flag(ovf2),
    .instr_count(count2)
  );

  // X/Y/Z register + ALU datapath model
  logic signed [7:0] x_r, y_r, z_r;
  logic        [7:0] kbd_data;
  logic              preset_en;
  logic        [7:0] preset_y;
  logic signed [8:0] wide;

  always_comb begin
    wide    = tula ? ({y_r[7], y_r} - {x_r[7], x_r}) : ({y_r[7], y_r} + {x_r[7], x_r});
    alu_ovf = (wide[8] != wide[7]);
  end

  always @(posedge clk) begin
    case (tx)
      2'b00:   x_r <= '0;
      2'b01:   x_r <= kbd_data;
      default: ;
    endcase
    if (preset_en) y_r <= preset_y;
    else begin
      case (ty)
        2'b00:   y_r <= '0;
        2'b01:   y_r <= wide[7:0];
        default: ;
      endcase
    end
    case (tz)
      2'b00:   z_r <= '0;
      2'b01:   z_r <= y_r;
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [1:0] obs_tx, obs_ty, obs_tz;
  logic       obs_tula, obs_busy, obs_ready, obs_err, obs_ovf;
  int         obs_lat;

  // Hands one opcode over, captures the first post-accept cycle, then
  // returns at the negedge of the done cycle (obs_lat=0 if done never came).
  task automatic run_op(input logic [2:0] code, input logic [7:0] kbd);
    int n;
    kbd_data = kbd;
    n = 0;
    while (instr_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", int'(instr_ready), 1);
    instr_valid = 1'b1;
    instr_code  = code;
    @(negedge clk);
    instr_valid = 1'b0;
    obs_tx = tx; obs_ty = ty; obs_tz = tz; obs_tula = tula;
    obs_busy = busy; obs_ready = instr_ready; obs_ovf = ovf_flag;
    obs_lat = 0;
    obs_err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        obs_lat = c;
        obs_err = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic preset(input logic [7:0] val);
    preset_en = 1'b1;
    preset_y  = val;
    @(negedge clk);
    preset_en = 1'b0;
  endtask

  typedef struct {
    logic [2:0] code;
    logic [7:0] kbd;
    logic [1:0] etx, ety, etz;
    logic       etula;
    logic       eerr;
    int         elat;
    int         ecount;
    int         ey;
  } vec_t;

  vec_t vecs[8];
  int   exp2[5];

  initial begin
    vecs[0] = '{OP_LOAD,  8'd5, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 4, 1, 3};
    vecs[1] = '{OP_ADD,   8'd5, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 4, 2, 8};
    vecs[2] = '{OP_DISP,  8'd5, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 4, 3, 8};
    vecs[3] = '{3'b110,   8'd5, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1, 1, 3, 8};
    vecs[4] = '{OP_SUB,   8'd5, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0, 4, 4, 8};
    vecs[5] = '{OP_DISP,  8'd5, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0, 4, 5, 8};
    vecs[6] = '{OP_CLRLD, 8'd5, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4, 6, 0};
    vecs[7] = '{3'b111,   8'd5, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1, 6, 0};
    exp2 = '{1, 2, 3, 0, 1};

    rst = 1'b1; instr_valid = 1'b1; instr_code = OP_LOAD; kbd_data = 8'd0;
    preset_en = 1'b0; preset_y = 8'd0; v2 = 1'b0; c2 = OP_LOAD;

    // T1: reset held with a valid opcode pending
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(tx), 2); chk("rst_ty", int'(ty), 2); chk("rst_tz", int'(tz), 2);
      chk("rst_ready", int'(instr_ready), 0);
      chk("rst_count", int'(instr_count), 0);
      chk("rst_busy", int'(busy), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(instr_ready), 1);
    chk("post_rst_count", int'(instr_count), 0);
    chk("post_rst_busy", int'(busy), 0);
    instr_valid = 1'b0;
    @(negedge clk);

    // T2/T4 and mixed sequence, table-driven
    preset(8'd3);
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].code, vecs[i].kbd);
      chk($sformatf("v%0d_tx", i), int'(obs_tx), int'(vecs[i].etx));
      chk($sformatf("v%0d_ty", i), int'(obs_ty), int'(vecs[i].ety));
      chk($sformatf("v%0d_tz", i), int'(obs_tz), int'(vecs[i].etz));
      chk($sformatf("v%0d_tula", i), int'(obs_tula), int'(vecs[i].etula));
      chk($sformatf("v%0d_busy", i), int'(obs_busy), 1);
      chk($sformatf("v%0d_ready", i), int'(obs_ready), 0);
      chk($sformatf("v%0d_lat", i), obs_lat, vecs[i].elat);
      chk($sformatf("v%0d_err", i), int'(obs_err), int'(vecs[i].eerr));
      chk($sformatf("v%0d_count", i), int'(instr_count), vecs[i].ecount);
      chk($sformatf("v%0d_y", i), int'(y_r), vecs[i].ey);
      chk($sformatf("v%0d_ovf", i), int'(ovf_flag), 0);
      chk($sformatf("v%0d_hold_tx", i), int'(tx), 2);
    end
    exp_cnt = 6;

    // T3: SUB overflow, sticky through DISP, cleared by CLRLD
    preset(8'h9C);
    run_op(OP_LOAD, 8'd100);
    run_op(OP_SUB, 8'd100);
    chk("t3_sub_tula", int'(obs_tula), 1);
    chk("t3_sub_y", int'(y_r), 56);
    chk("t3_sub_ovf", int'(ovf_flag), 1);
    run_op(OP_DISP, 8'd0);
    chk("t3_disp_ovf", int'(ovf_flag), 1);
    run_op(OP_CLRLD, 8'd0);
    chk("t3_clr_tx", int'(obs_tx), 0);
    chk("t3_clr_ty", int'(obs_ty), 0);
    chk("t3_clr_tz", int'(obs_tz), 0);
    chk("t3_clr_ovf_exec", int'(obs_ovf), 1);
    chk("t3_clr_ovf_done", int'(ovf_flag), 0);
    chk("t3_clr_hold_tz", int'(tz), 2);
    exp_cnt += 4;
    chk("t3_count", int'(instr_count), exp_cnt);

    // T5: DISP held valid for 10 cycles
    begin
      int pulses = 0, first = -1, second = -1, viol = 0, n = 0;
      while (instr_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      instr_valid = 1'b1;
      instr_code  = OP_DISP;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (tz == 2'b01) begin
          pulses++;
          if (first < 0) first = c;
          else if (second < 0) second = c;
        end
        if (busy && instr_ready) viol++;
      end
      instr_valid = 1'b0;
      chk("t5_pulses", pulses, 2);
      chk("t5_first", first, 1);
      chk("t5_second", second, 6);
      chk("t5_ready_busy", viol, 0);
      exp_cnt += 2;
      chk("t5_count", int'(instr_count), exp_cnt);
    end

    // T6: reset during SETTLE of an overflowing ADD
    begin
      int n = 0;
      run_op(OP_LOAD, 8'd1);
      preset(8'd127);
      while (instr_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      instr_valid = 1'b1;
      instr_code  = OP_ADD;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("t6_exec_tula", int'(tula), 0);
      @(negedge clk);
      chk("t6_settle_ovf", int'(ovf_flag), 1);
      chk("t6_settle_busy", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_done", int'(done), 0);
      chk("t6_rst_ty", int'(ty), 2);
      chk("t6_rst_ovf", int'(ovf_flag), 0);
      chk("t6_rst_count", int'(instr_count), 0);
      chk("t6_rst_ready", int'(instr_ready), 0);
      rst = 1'b0;
      run_op(OP_LOAD, 8'd7);
      chk("t6_load_tx", int'(obs_tx), 1);
      chk("t6_load_lat", obs_lat, 4);
      chk("t6_load_count", int'(instr_count), 1);
      chk("t6_load_err", int'(obs_err), 0);
    end

    // T7: narrow counter wraps
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      while (ready2 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      v2 = 1'b1;
      c2 = OP_LOAD;
      @(negedge clk);
      v2 = 1'b0;
      n = 0;
      while (done2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk($sformatf("t7_done_%0d", i), int'(done2), 1);
      chk($sformatf("t7_count_%0d", i), int'(count2), exp2[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
